// File: rtl/full_subtractor_if.sv
// Operand/result bus for full_subtractor.
// Build option FULL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
interface full_subtractor_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic [WIDTH-1:0] sub;
  logic             bor;
  logic             out_valid;
`ifdef FULL_SUB_OVF_EN
  logic             ovf;

  modport master (output a, b, bin, in_valid, input sub, bor, out_valid, ovf);
  modport slave  (input a, b, bin, in_valid, output sub, bor, out_valid, ovf);
`else
  modport master (output a, b, bin, in_valid, input sub, bor, out_valid);
  modport slave  (input a, b, bin, in_valid, output sub, bor, out_valid);
`endif
endinterface

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bor, sub} = a - b - bin,
// one cycle of latency, capture gated by in_valid, synchronous active-low reset.
// Build option FULL_SUB_OVF_EN adds ovf = br[WIDTH] ^ br[WIDTH-1].

// One bit of the ripple chain.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  full_subtractor_if.slave    bus
);
  localparam int STAGES = 1;

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] sub_q;
  logic             bor_q;
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;

  assign br[0] = bus.bin;

  // Ripple chain: lane i consumes br[i] and produces br[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    full_subtractor_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .bi (br[i]),
      .d  (d[i]),
      .bo (br[i+1])
    );
  end

  // Stage 0 is the incoming valid; registered stages follow.
  always_comb vld_pipe = {vld_q, bus.in_valid};

  // Valid shift register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

  // Result register: capture on accepted operands, otherwise hold, so
  // operand values while in_valid is low never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= '0;
      bor_q <= 1'b0;
    end else if (vld_pipe[0]) begin
      sub_q <= d;
      bor_q <= br[WIDTH];
    end
  end

  assign bus.sub       = sub_q;
  assign bus.bor       = bor_q;
  assign bus.out_valid = vld_pipe[STAGES];

`ifdef FULL_SUB_OVF_EN
  logic ovf_q;

  // Signed overflow: carries into and out of the sign lane disagree.
  always_ff @(posedge clk) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (vld_pipe[0])  ovf_q <= br[WIDTH] ^ br[WIDTH-1];
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: WIDTH=1 and WIDTH=8 instances,
// directed tables, reset/hold corners and a randomized run against an
// arithmetic reference model.
module tb_full_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_subtractor_if #(.WIDTH(1)) bus1 ();
  full_subtractor_if #(.WIDTH(8)) bus8 ();

  full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  full_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic       a;
    logic       b;
    logic       bin;
    logic       sub;
    logic       bor;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] sub;
    logic       bor;
    logic       ovf;
  } vec8_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input int a, input int b, input int bin,
                       output int sub, output int bor, output int ovf);
    int r, sa, sb, rs;
    r   = a - b - bin;
    bor = (r < 0) ? 1 : 0;
    sub = (r + (1 << w)) % (1 << w);
    sa  = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb  = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    rs  = sa - sb - bin;
    ovf = (rs < -(1 << (w - 1)) || rs > (1 << (w - 1)) - 1) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] sub, input logic bor, input logic ovf);
    check({name, ".sub"}, 32'(bus8.sub), 32'(sub));
    check({name, ".bor"}, 32'(bus8.bor), 32'(bor));
`ifdef FULL_SUB_OVF_EN
    check({name, ".ovf"}, 32'(bus8.ovf), 32'(ovf));
`else
    if (ovf === 1'bx) $display("unused ovf");
`endif
  endtask

  vec1_t t1[8];
  vec8_t t8[3];

  initial begin
    int es, eb, eo;
    logic [7:0] hold_sub;
    logic       hold_bor;

    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t1[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t1[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    t8[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    t8[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    t8[2] = '{8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};

    // Reset held for two cycles with live valid operands.
    rst_n = 1'b0;
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.bin = 1'b0; bus1.in_valid = 1'b1;
    bus8.a = 8'hFF; bus8.b = 8'h00; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
    tick();
    tick();
    check("rst.sub1", 32'(bus1.sub), 0);
    check("rst.bor1", 32'(bus1.bor), 0);
    check("rst.vld1", 32'(bus1.out_valid), 0);
    chk8("rst8", 8'h00, 1'b0, 1'b0);
    check("rst.vld8", 32'(bus8.out_valid), 0);

    // Release: first result one cycle after in_valid.
    rst_n = 1'b1;
    tick();
    check("first.vld8", 32'(bus8.out_valid), 1);
    chk8("first8", 8'hFF, 1'b0, 1'b0);

    // WIDTH=1 truth table, one vector per cycle.
    foreach (t1[i]) begin
      bus1.a = t1[i].a; bus1.b = t1[i].b; bus1.bin = t1[i].bin; bus1.in_valid = 1'b1;
      tick();
      check($sformatf("tt%0d.sub", i), 32'(bus1.sub), 32'(t1[i].sub));
      check($sformatf("tt%0d.bor", i), 32'(bus1.bor), 32'(t1[i].bor));
      check($sformatf("tt%0d.vld", i), 32'(bus1.out_valid), 1);
`ifdef FULL_SUB_OVF_EN
      check($sformatf("tt%0d.ovf", i), 32'(bus1.ovf), 32'(t1[i].bor ^ t1[i].bin));
`endif
    end

    // Hold: valid capture then idle with different operands.
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.bin = 1'b0; bus1.in_valid = 1'b1;
    tick();
    check("hold.cap.sub", 32'(bus1.sub), 1);
    check("hold.cap.bor", 32'(bus1.bor), 0);
    bus1.a = 1'b0; bus1.b = 1'b1; bus1.in_valid = 1'b0;
    tick();
    check("hold.sub", 32'(bus1.sub), 1);
    check("hold.bor", 32'(bus1.bor), 0);
    check("hold.vld", 32'(bus1.out_valid), 0);

    // WIDTH=8 directed cases, back to back.
    foreach (t8[i]) begin
      bus8.a = t8[i].a; bus8.b = t8[i].b; bus8.bin = t8[i].bin; bus8.in_valid = 1'b1;
      tick();
      chk8($sformatf("w8_%0d", i), t8[i].sub, t8[i].bor, t8[i].ovf);
      check($sformatf("w8_%0d.vld", i), 32'(bus8.out_valid), 1);
    end

    // Reset mid-stream: the operands presented with reset are lost.
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    chk8("mid.rst", 8'h00, 1'b0, 1'b0);
    check("mid.rst.vld", 32'(bus8.out_valid), 0);
    rst_n = 1'b1;
    bus8.in_valid = 1'b0;
    tick();
    chk8("mid.after", 8'h00, 1'b0, 1'b0);
    check("mid.after.vld", 32'(bus8.out_valid), 0);

    // Randomized run against the model, with idle cycles mixed in.
    hold_sub = 8'h00;
    hold_bor = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      bus8.in_valid = v;
      bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.bin = 1'($urandom);
      bus1.in_valid = 1'b1;
      model(8, int'(bus8.a), int'(bus8.b), int'(bus8.bin), es, eb, eo);
      if (v) begin
        hold_sub = 8'(es);
        hold_bor = 1'(eb);
      end
      begin
        int s1, b1, o1;
        model(1, int'(bus1.a), int'(bus1.b), int'(bus1.bin), s1, b1, o1);
        tick();
        check("rnd1.sub", 32'(bus1.sub), 32'(s1));
        check("rnd1.bor", 32'(bus1.bor), 32'(b1));
`ifdef FULL_SUB_OVF_EN
        check("rnd1.ovf", 32'(bus1.ovf), 32'(o1));
`endif
      end
      check("rnd8.vld", 32'(bus8.out_valid), 32'(v));
      check("rnd8.sub", 32'(bus8.sub), 32'(hold_sub));
      check("rnd8.bor", 32'(bus8.bor), 32'(hold_bor));
`ifdef FULL_SUB_OVF_EN
      if (v) check("rnd8.ovf", 32'(bus8.ovf), 32'(eo));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor: computes a − b − bin per bit lane, producing difference `sub` and borrow-out `bor`.
- Lanes are chained as a WIDTH-bit ripple-borrow subtractor.
- With WIDTH=1 it is the classic single-bit full subtractor, with its outputs captured in a register.
- Used as a leaf arithmetic cell inside datapaths that need synchronous, reset-clean subtraction results.

Parameters:
- WIDTH, 1, operand width in bits (≥1); bit 0 takes `bin`, the borrow ripples upward.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in to bit 0.
- in_valid  input  1  operands valid this cycle; result is captured only when high.
- sub  output  WIDTH  registered difference.
- bor  output  1  registered borrow-out from the MSB.
- out_valid  output  1  high the cycle after an accepted operand set.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Per-bit combinational cell, bit i, with borrow-in br[i] and br[0] = bin:
  - d[i] = a[i] ^ b[i] ^ br[i]
  - br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])
- Register capture: bor = br[WIDTH].
  - Equivalently: {bor, sub} = {1'b0, a} − {1'b0, b} − bin, in WIDTH+1-bit two's-complement arithmetic.
  - bor = 1 exactly when a < b + bin, treating both as unsigned.
- Reset: when rst_n = 0 at a rising edge, sub ← 0, bor ← 0, out_valid ← 0.
  - Reset has priority over in_valid.
  - Reset mid-stream discards the pending result.
- Operation: at a rising edge with rst_n = 1 and in_valid = 1:
  - sub, bor ← computed result; out_valid ← 1.
  - Latency is exactly 1 cycle.
  - Back-to-back inputs are accepted every cycle; there is no stall or backpressure.
- Hold: at a rising edge with rst_n = 1 and in_valid = 0:
  - sub and bor hold their previous values; out_valid ← 0.
- Boundaries:
  - a = b, bin = 0 → sub = 0, bor = 0.
  - a = 0, b = all-ones, bin = 1 → sub = 0, bor = 1 (full wrap).
  - a = all-ones, b = 0, bin = 0 → sub = all-ones, bor = 0.
- No combinational path from inputs to outputs.
- X on inputs while in_valid = 0 must not affect the outputs.

Optional Feature:
- Macro: FULL_SUB_OVF_EN.
- When defined, an extra output `ovf` (1 bit, registered) is added.
  - ovf = signed overflow of a − b − bin, treating a and b as WIDTH-bit two's-complement values: ovf = br[WIDTH] ^ br[WIDTH−1].
  - For WIDTH = 1, ovf = bor ^ bin.
  - ovf follows the same reset (0), capture and hold rules as `bor`.
- When not defined, the `ovf` port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1 truth table, driven with in_valid=1, one vector per cycle, checked one cycle later as (a,b,bin) → (sub,bor):
  - 000 → 0,0
  - 010 → 1,1
  - 110 → 0,0
  - 100 → 1,0
  - 001 → 1,1
  - 011 → 0,1
  - 111 → 1,1
  - 101 → 0,0
- Reset: drive operands with rst_n = 0 for 2 cycles → sub = 0, bor = 0, out_valid = 0; then release → first result appears 1 cycle after in_valid.
- Hold: in_valid = 1 with a=1, b=0, bin=0 → sub = 1, bor = 0; then in_valid = 0 with a=0, b=1 → sub stays 1, bor stays 0, out_valid = 0.
- WIDTH=8 wrap: a=8'h00, b=8'hFF, bin=1 → sub = 8'h00, bor = 1.
- WIDTH=8 other cases:
  - a=8'h80, b=8'h01, bin=0 → sub = 8'h7F, bor = 0 (ovf = 1 with FULL_SUB_OVF_EN).
  - a=8'h05, b=8'h03, bin=1 → sub = 8'h01, bor = 0.
- Reset mid-stream: in_valid = 1 and rst_n = 0 at the same edge → outputs go to 0 and out_valid = 0; the result for that input is never produced.
